// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M divide path.
// Op encodings, FSM states and fixed operand constants.
package mdu_pkg;

    localparam logic [1:0] DIV_OP  = 2'b00;
    localparam logic [1:0] DIVU_OP = 2'b01;
    localparam logic [1:0] REM_OP  = 2'b10;
    localparam logic [1:0] REMU_OP = 2'b11;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/mdu_div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and overflow finish in one cycle.
import mdu_pkg::*;

module mdu_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    state_t state;
    state_t state_nxt;

    logic [1:0]      op_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] result_q;

    logic            sgn;
    logic            div0;
    logic            ovf;
    logic            last;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] q_step;
    logic [XLEN:0]   r_step;
    logic [XLEN-1:0] fin_val;
    logic [XLEN-1:0] special_val;
    logic            unused_msb;

    function automatic logic [XLEN-1:0] neg_if(
        input logic [XLEN-1:0] v,
        input logic            c
    );
        return c ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [XLEN-1:0] abs_val(
        input logic [XLEN-1:0] v,
        input logic            signed_op
    );
        return neg_if(v, signed_op & v[XLEN-1]);
    endfunction

    // DIV and REM are signed; the low op bit marks the unsigned variants.
    assign sgn  = ~op[0];
    assign div0 = (rs2 == '0);
    assign ovf  = sgn & (rs1 == INT_MIN) & (rs2 == ALL_ONES);
    assign last = (cnt_q == CW'(XLEN - 1));

    // Remainder lives in the low XLEN bits; its top bit only exposes the borrow.
    assign shifted = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign q_step  = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign r_step  = diff[XLEN] ? shifted : diff;

    assign fin_val = op_q[1] ? neg_if(r_step[XLEN-1:0], neg_r)
                             : neg_if(q_step, neg_q);

    assign special_val = div0 ? (op[1] ? rs1 : ALL_ONES)
                              : (op[1] ? '0  : INT_MIN);

    assign unused_msb = ^{rem_q[XLEN], r_step[XLEN]};

    assign result = result_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (div0 | ovf) ? FIN : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, shift/subtract iteration and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        quo_q <= abs_val(rs1, sgn);
                        dvs_q <= abs_val(rs2, sgn);
                        rem_q <= '0;
                        cnt_q <= '0;
                        neg_q <= sgn & (rs1[XLEN-1] ^ rs2[XLEN-1]);
                        neg_r <= sgn & rs1[XLEN-1];
                        if (div0 | ovf) begin
                            result_q <= special_val;
                        end
                    end
                end
                CALC: begin
                    quo_q <= q_step;
                    rem_q <= r_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        result_q <= fin_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_div_iter.sv
// Directed bench for mdu_div_iter.
// Vector table plus hand sequences for start-while-busy and mid-run reset.
module tb_mdu_div_iter;
    import mdu_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_chk = 0;
    int n_err = 0;

    vec_t vecs[16];

    mdu_div_iter #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch one op, scramble inputs while it runs, check every cycle.
    task automatic run(input vec_t v, input int idx);
        string tag;
        tag   = $sformatf("v%0d", idx);
        op    = v.op;
        rs1   = v.a;
        rs2   = v.b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 2'($urandom);
        rs1   = $urandom;
        rs2   = $urandom;
        for (int k = 1; k <= v.lat + 3; k++) begin
            chk({tag, " busy"}, 32'(busy), 32'(k <= v.lat));
            chk({tag, " done"}, 32'(done), 32'(k == v.lat));
            if (k >= v.lat) chk({tag, " result"}, result, v.exp);
            tick();
        end
    endtask

    initial begin
        vecs[0]  = '{DIV_OP,  32'd20,         32'hFFFFFFFD, 32'hFFFFFFFA, 33};
        vecs[1]  = '{REM_OP,  32'hFFFFFFEC,   32'd3,        32'hFFFFFFFE, 33};
        vecs[2]  = '{REMU_OP, 32'hFFFFFFEC,   32'd3,        32'd2,        33};
        vecs[3]  = '{DIVU_OP, 32'hFFFFFFFF,   32'd2,        32'h7FFFFFFF, 33};
        vecs[4]  = '{REMU_OP, 32'hFFFFFFFF,   32'd2,        32'd1,        33};
        vecs[5]  = '{DIV_OP,  32'd7,          32'd0,        32'hFFFFFFFF, 1};
        vecs[6]  = '{REM_OP,  32'd7,          32'd0,        32'd7,        1};
        vecs[7]  = '{DIVU_OP, 32'd0,          32'd0,        32'hFFFFFFFF, 1};
        vecs[8]  = '{DIV_OP,  32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1};
        vecs[9]  = '{REM_OP,  32'h80000000,   32'hFFFFFFFF, 32'd0,        1};
        vecs[10] = '{REMU_OP, 32'd7,          32'd0,        32'd7,        1};
        vecs[11] = '{DIV_OP,  32'h80000000,   32'd1,        32'h80000000, 33};
        vecs[12] = '{DIV_OP,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
        vecs[13] = '{REM_OP,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
        vecs[14] = '{DIVU_OP, 32'h80000000,   32'hFFFFFFFF, 32'd0,        33};
        vecs[15] = '{REMU_OP, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 33};

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        rs1   = '0;
        rs2   = '0;
        tick();
        tick();
        chk("reset busy",   32'(busy), 32'd0);
        chk("reset done",   32'(done), 32'd0);
        chk("reset result", result,    32'd0);

        // Reset and start together: start must be dropped.
        op    = DIVU_OP;
        rs1   = 32'd100;
        rs2   = 32'd7;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rst+start busy", 32'(busy), 32'd0);
            chk("rst+start done", 32'(done), 32'd0);
            tick();
        end

        for (int i = 0; i < 16; i++) begin
            run(vecs[i], i);
        end

        // DIVU 100/7 with a second start pulse while busy.
        op    = DIVU_OP;
        rs1   = 32'd100;
        rs2   = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            chk("ign busy", 32'(busy), 32'(k <= 33));
            chk("ign done", 32'(done), 32'(k == 33));
            if (k >= 33) chk("ign result", result, 32'd14);
            if (k == 5) begin
                start = 1'b1;
                op    = DIV_OP;
                rs1   = 32'd50;
                rs2   = 32'd5;
            end
            if (k == 6) start = 1'b0;
            tick();
        end

        // Reset during iteration 10 aborts with no done pulse.
        op    = DIVU_OP;
        rs1   = 32'd100;
        rs2   = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            chk("abort busy", 32'(busy), 32'd1);
            chk("abort done", 32'(done), 32'd0);
            if (k == 11) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        chk("abort rst busy",   32'(busy), 32'd0);
        chk("abort rst done",   32'(done), 32'd0);
        chk("abort rst result", result,    32'd0);
        for (int k = 0; k < 40; k++) begin
            chk("abort no done", 32'(done), 32'd0);
            chk("abort idle",    32'(busy), 32'd0);
            tick();
        end

        run('{DIV_OP, 32'd9, 32'd3, 32'd3, 33}, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_div_iter.md
Name: mdu_div_iter

Overview:
Iterative radix-2 restoring divider that produces the DIV/DIVU/REM/REMU results for the RV32M multiply/divide unit. It sits directly upstream of the MDU result path: the MDU launches it with operands from the register file and forwards its result onto mdu_result. It uses a start/busy/done handshake, which the MDU maps onto its valid/ready signalling to stall the core. Divide-by-zero and signed overflow complete on a one-cycle fast path.

Parameters:
XLEN, 32, operand/result width in bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  launch request; accepted only when busy=0.
op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0] of the M-extension divide group).
rs1  input  XLEN  dividend; sampled on the accepted start edge only.
rs2  input  XLEN  divisor; sampled on the accepted start edge only.
busy  output  1  high from the cycle after an accepted start until the cycle done is high, inclusive.
done  output  1  one-cycle pulse; result is valid in this cycle.
result  output  XLEN  quotient or remainder, selected by op; held until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers 0.
- States:
  - IDLE: on start=1, latch op and operands. If rs2=0, or (op=DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF), go to FIN with the special-case result. Otherwise go to CALC with count=0.
  - CALC: one quotient bit per cycle, MSB first. Each cycle: shift the remainder left, bring in the next dividend bit, trial-subtract |divisor|, and keep the difference if it is non-negative (quotient bit = 1).
    - count increments each cycle.
    - After the 32nd iteration (count=31 edge), go to FIN.
  - FIN: done=1, busy=1, result drives the final value. Next edge returns to IDLE; done drops and result holds.
- Latency: start high in cycle n gives done in cycle n+33 on the normal path, and in cycle n+1 on the fast path. Throughput is one division per 34 cycles: the next start is accepted no earlier than the IDLE cycle after FIN.
- Sign handling for DIV/REM:
  - Operate on absolute values.
  - Negate the quotient iff the operand signs differ.
  - Negate the remainder iff the dividend is negative; the remainder takes the sign of the dividend.
  - Sign fix-up is applied when entering FIN.
- DIVU/REMU: pure unsigned, no fix-up.
- Special cases (RISC-V spec):
  - Divide by zero: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = rs1.
  - Overflow (-2^31 / -1): quotient = 0x80000000, remainder = 0.
- Arithmetic width: the remainder register is XLEN+1 bits so the trial subtraction sign bit is explicit; no other extra width.
- start while busy=1: ignored, with no effect on the operation in flight.
- start in the same cycle as FIN: ignored, because busy=1.
- rs1/rs2/op changing during CALC: no effect, since operands are latched.
- rst=1 at any point, including mid-CALC: the next edge forces all reset values. No done pulse is produced for the aborted operation.
- rst and start high in the same cycle: reset wins and start is dropped.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings DIV_OP=2'b00, DIVU_OP=2'b01, REM_OP=2'b10, REMU_OP=2'b11;
  - state enum {IDLE, CALC, FIN};
  - constants INT_MIN=32'h80000000 and ALL_ONES=32'hFFFFFFFF.
- No sub-module is required. Sign/abs/negate logic stays as local functions; a separate module for it would be a thin wrapper.

Test Plan:
1. DIV rs1=20, rs2=0xFFFFFFFD (-3), start in cycle n -> busy high cycles n+1..n+33; done only in cycle n+33; result=0xFFFFFFFA (-6).
2. REM rs1=0xFFFFFFEC (-20), rs2=3 -> done at n+33; result=0xFFFFFFFE (-2). Then REMU with the same operands -> result=0x00000002.
3. DIVU rs1=0xFFFFFFFF, rs2=2 -> result=0x7FFFFFFF. Then REMU with the same operands -> result=1. result stays stable after done until the next start.
4. DIV 7/0 -> done at n+1, result=0xFFFFFFFF. REM 7/0 -> done at n+1, result=7. DIVU 0/0 -> result=0xFFFFFFFF.
5. DIV 0x80000000 / 0xFFFFFFFF -> done at n+1, result=0x80000000. REM with the same operands -> result=0.
6. Start DIVU 100/7. Pulse start with different operands at cycle n+5 -> ignored; result=14 at n+33. Then start again and assert rst at iteration 10 -> next cycle busy=0, done=0, result=0, and no done pulse follows. A fresh DIV 9/3 -> result=3 at its n+33.
